usb_fs_transmitter: RTL and testbench
=====================================

# usb_fs_transmitter

Full-speed USB transmit path. Takes packet bytes over a valid/ready handshake and frames them with SYNC. Serialises each byte LSB-first with bit stuffing and NRZI encoding, then terminates the packet with EOP. It drives the differential pair plus `OE_TRANSMIT`; the top level uses `OE_TRANSMIT` for the pad tristates and feeds it back to the receive path for stuff-bit handling during transmit.

## Interface
- `CLKS_PER_BIT`, 10: `useClk` cycles per USB bit time (same oversampling as the receive path).
- `useClk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `txData`  in  8  packet byte (PID first), sent LSB first.
- `txValid`  in  1  `txData`/`txLast` valid; in IDLE it also requests a new packet.
- `txLast`  in  1  marks the final byte of the packet, qualified with `txValid`.
- `txReady`  out  1  one-cycle pulse: byte on `txData` consumed this edge.
- `serialDataOut`  out  1  D+ level.
- `NotserialDataOut`  out  1  D− level.
- `OE_TRANSMIT`  out  1  high while the block owns the bus.
- `busy`  out  1  high from packet start until the end of the inter-packet gap.
- `underrun`  out  1  one-cycle pulse when a byte is needed and `txValid` is low before `txLast`.

## Operation
- Reset values: `serialDataOut`=1, `NotserialDataOut`=0 (J), `OE_TRANSMIT`=0, `txReady`=0, `busy`=0, `underrun`=0.
- Reset state: FSM in IDLE, divider=0, stuff counter=0.
- Reset mid-packet: return to reset values at the next edge. No EOP is sent.
- Line states: J = (1,0); K = (0,1); SE0 = (0,0). SE1 is never driven.
- While `OE_TRANSMIT`=0, the outputs hold J.
- FSM states: IDLE → SYNC → DATA ⇄ STUFF → EOP_SE0 → EOP_J → GAP → IDLE.
- IDLE: when `txValid`=1, go to SYNC.
- SYNC: 8 bits, logical pattern 0,0,0,0,0,0,0,1. Stuffing logic counts these bits.
- DATA: at each byte boundary with `txValid`=1, load the shift register and pulse `txReady`.
  - Latch `txLast` along with the byte.
  - After the last bit of a `txLast` byte, go to EOP_SE0. A pending stuff bit goes first.
- NRZI encoding: logical 0 toggles J↔K; logical 1 holds the line. The encoder state starts at J.
- Stuffing: count consecutive logical 1s across SYNC, data and byte boundaries.
  - When the count reaches 6, the next bit time is a stuffed 0 (STUFF state, line toggles) and the count resets to 0.
  - A data 0 also resets the count.
  - A stuff bit is owed when the count reaches 6 at a byte boundary, including after the final byte. It is inserted before the next byte loads or before EOP.
- EOP_SE0: 2 bit times of SE0.
- EOP_J: 1 bit time of J, then `OE_TRANSMIT` drops.
- GAP: 2 bit times with `OE_TRANSMIT`=0 and `busy`=1. `txValid` is ignored, then return to IDLE.
- Underrun: when a byte boundary arrives (not after `txLast`) and `txValid`=0:
  - pulse `underrun` on the boundary edge;
  - go directly to EOP_SE0 (still inserting an owed stuff bit first).
- `txReady` is never asserted in IDLE, SYNC, EOP or GAP.

## Timing
- Bit time: exactly `CLKS_PER_BIT` cycles. The divider restarts at 0 on the packet-start edge.
- Packet start: the edge where IDLE sees `txValid`=1 sets `OE_TRANSMIT`=1 and drives the first SYNC bit (K) on the same edge. Call this edge T0.
- `txReady` for byte k (k=0 first) pulses at T0 + (8 + 8k + s)·N.
  - N = `CLKS_PER_BIT`.
  - s = number of stuff bits sent before that byte.
- `OE_TRANSMIT` high duration: (8 + 8n + S + 3)·N cycles, for n bytes and S stuff bits total.
- `busy` falls 2N cycles after `OE_TRANSMIT` falls.
- Minimum: a new packet can start on the first IDLE cycle after `busy` falls.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Simultaneous `rst` and `txValid`: `rst` wins.

## Test plan
- One byte 0xC3, `txLast`=1, N=10 → line K,J,K,J,K,J,K,K then the NRZI of 1,1,0,0,0,0,1,1; `txReady` at T0+80; SE0 at T0+160..179; J at 180..189; `OE_TRANSMIT` low from T0+190; `busy` low from T0+210.
- Bytes 0xFF, 0xFF (last) → stuff after bit 5 of byte 0 and after bit 3 of byte 1; `txReady` at T0+80 and T0+170; `OE_TRANSMIT` high 290 cycles; the receive path decodes 0xFF, 0xFF with both stuff bits removed.
- One byte 0xFC, last → 6 trailing 1s, stuff bit before EOP; `OE_TRANSMIT` high 200 cycles.
- Byte 0x01 without `txLast`, then `txValid`=0 → `underrun` pulse at T0+160; SE0 starts at T0+160; no second `txReady`.
- `rst` asserted at T0+95 → at the next edge, outputs are J, `OE_TRANSMIT`=0, `busy`=0; a new `txValid` starts a fresh SYNC.
- `txValid` held high through two packets → second T0 is exactly 20 cycles after the first `OE_TRANSMIT` falls; no `txReady` during GAP.

Source files
------------

// File: rtl/usb_fs_transmitter_if.sv
// Byte handshake between a packet source and the full-speed USB transmitter.
interface usb_fs_transmitter_if;
  logic [7:0] txData;
  logic       txValid;
  logic       txLast;
  logic       txReady;

  modport master (output txData, output txValid, output txLast, input txReady);
  modport slave  (input txData, input txValid, input txLast, output txReady);
endinterface

// File: rtl/usb_fs_transmitter.sv
// Full-speed USB transmit path: SYNC framing, LSB-first serialisation,
// bit stuffing, NRZI encoding, EOP and inter-packet gap.
module usb_fs_transmitter #(
  parameter int unsigned CLKS_PER_BIT = 10
) (
  input  logic                 useClk,
  input  logic                 rst,
  usb_fs_transmitter_if.slave  tx,
  output logic                 serialDataOut,
  output logic                 NotserialDataOut,
  output logic                 OE_TRANSMIT,
  output logic                 busy,
  output logic                 underrun
);

  localparam int unsigned DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_STUFF,
    S_EOP_SE0,
    S_EOP_J,
    S_GAP
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [6:0]       sreg_q, sreg_d;      // remaining bits of the current byte
  logic             last_q, last_d;
  logic             stuff_bnd_q, stuff_bnd_d;
  logic [2:0]       ones_q, ones_d;
  logic             nrzi_q, nrzi_d;      // 1 = J, 0 = K
  logic             oe_q, oe_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             underrun_q, underrun_d;
  logic             dp_q, dp_d;
  logic             dm_q, dm_d;

  logic             bit_end;
  logic             do_bnd;
  logic             do_start;
  logic             emit_en;
  logic             emit_bit;
  logic             se0;

  assign bit_end = (div_q == DIV_LAST);

  // Next-state, bit sequencing, stuffing and NRZI line computation
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    sreg_d      = sreg_q;
    last_d      = last_q;
    stuff_bnd_d = stuff_bnd_q;
    ones_d      = ones_q;
    nrzi_d      = nrzi_q;
    oe_d        = oe_q;
    busy_d      = busy_q;
    ready_d     = 1'b0;
    underrun_d  = 1'b0;
    do_bnd      = 1'b0;
    do_start    = 1'b0;
    emit_en     = 1'b0;
    emit_bit    = 1'b0;

    if (state_q != S_IDLE) begin
      div_d = bit_end ? '0 : div_q + DIV_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (tx.txValid) do_start = 1'b1;
      end
      S_SYNC: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            do_bnd = 1'b1;
          end else begin
            bit_d    = bit_q + 3'd1;
            emit_en  = 1'b1;
            emit_bit = (bit_q == 3'd6);
          end
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (ones_q == 3'd6) begin
            state_d     = S_STUFF;
            stuff_bnd_d = (bit_q == 3'd7);
            emit_en     = 1'b1;
            emit_bit    = 1'b0;
          end else if (bit_q == 3'd7) begin
            do_bnd = 1'b1;
          end else begin
            bit_d    = bit_q + 3'd1;
            sreg_d   = {1'b0, sreg_q[6:1]};
            emit_en  = 1'b1;
            emit_bit = sreg_q[0];
          end
        end
      end
      S_STUFF: begin
        if (bit_end) begin
          if (stuff_bnd_q) begin
            do_bnd = 1'b1;
          end else begin
            state_d  = S_DATA;
            bit_d    = bit_q + 3'd1;
            sreg_d   = {1'b0, sreg_q[6:1]};
            emit_en  = 1'b1;
            emit_bit = sreg_q[0];
          end
        end
      end
      S_EOP_SE0: begin
        if (bit_end) begin
          if (bit_q == 3'd1) begin
            state_d = S_EOP_J;
            bit_d   = 3'd0;
            nrzi_d  = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_EOP_J: begin
        if (bit_end) begin
          state_d = S_GAP;
          bit_d   = 3'd0;
          oe_d    = 1'b0;
        end
      end
      S_GAP: begin
        if (bit_end) begin
          if (bit_q == 3'd1) begin
            if (tx.txValid) begin
              do_start = 1'b1;
            end else begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Byte boundary: finish the packet, load the next byte, or flag underrun
    if (do_bnd) begin
      bit_d       = 3'd0;
      stuff_bnd_d = 1'b0;
      if (last_q) begin
        state_d = S_EOP_SE0;
      end else if (tx.txValid) begin
        state_d  = S_DATA;
        sreg_d   = tx.txData[7:1];
        last_d   = tx.txLast;
        ready_d  = 1'b1;
        emit_en  = 1'b1;
        emit_bit = tx.txData[0];
      end else begin
        state_d    = S_EOP_SE0;
        underrun_d = 1'b1;
      end
    end

    // Packet start drives the first SYNC bit on the same edge
    if (do_start) begin
      state_d     = S_SYNC;
      div_d       = '0;
      bit_d       = 3'd0;
      last_d      = 1'b0;
      stuff_bnd_d = 1'b0;
      oe_d        = 1'b1;
      busy_d      = 1'b1;
      emit_en     = 1'b1;
      emit_bit    = 1'b0;
    end

    // NRZI: a logical 0 toggles the line; consecutive 1s feed the stuff counter
    if (emit_en) begin
      if (!emit_bit) nrzi_d = ~nrzi_q;
      ones_d = emit_bit ? (ones_q + 3'd1) : 3'd0;
    end

    se0  = (state_d == S_EOP_SE0);
    dp_d = oe_d ? (se0 ? 1'b0 : nrzi_d)  : 1'b1;
    dm_d = oe_d ? (se0 ? 1'b0 : ~nrzi_d) : 1'b0;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge useClk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      bit_q       <= 3'd0;
      sreg_q      <= 7'd0;
      last_q      <= 1'b0;
      stuff_bnd_q <= 1'b0;
      ones_q      <= 3'd0;
      nrzi_q      <= 1'b1;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
      underrun_q  <= 1'b0;
      dp_q        <= 1'b1;
      dm_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      sreg_q      <= sreg_d;
      last_q      <= last_d;
      stuff_bnd_q <= stuff_bnd_d;
      ones_q      <= ones_d;
      nrzi_q      <= nrzi_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      underrun_q  <= underrun_d;
      dp_q        <= dp_d;
      dm_q        <= dm_d;
    end
  end

  assign tx.txReady       = ready_q;
  assign serialDataOut    = dp_q;
  assign NotserialDataOut = dm_q;
  assign OE_TRANSMIT      = oe_q;
  assign busy             = busy_q;
  assign underrun         = underrun_q;

endmodule

// File: tb/tb_usb_fs_transmitter.sv
// Scoreboard bench for usb_fs_transmitter: directed packets, expected events,
// decoded bytes and line levels queued by the stimulus and checked by a monitor.
module tb_usb_fs_transmitter;

  localparam int unsigned N = 10;

  typedef enum int {EV_READY, EV_UNDERRUN, EV_SE0, EV_OE_FALL, EV_BUSY_FALL, EV_OE_RISE} ev_e;
  typedef struct {
    ev_e kind;
    int  off;
  } ev_t;

  logic useClk = 1'b0;
  logic rst;
  logic serialDataOut, NotserialDataOut, OE_TRANSMIT, busy, underrun;

  usb_fs_transmitter_if txif ();

  usb_fs_transmitter #(.CLKS_PER_BIT(N)) dut (
    .useClk           (useClk),
    .rst              (rst),
    .tx               (txif),
    .serialDataOut    (serialDataOut),
    .NotserialDataOut (NotserialDataOut),
    .OE_TRANSMIT      (OE_TRANSMIT),
    .busy             (busy),
    .underrun         (underrun)
  );

  always #5 useClk = ~useClk;

  int checks = 0;
  int passed = 0;

  ev_t        exp_ev_q[$];
  logic [7:0] exp_byte_q[$];
  bit         exp_line_q[$];   // 1 = J, 0 = K

  bit   mon_en = 1'b0;
  int   cyc = 0;
  int   t0 = 0;
  int   oe_fall_cyc = 0;
  bit   oe_prev = 1'b0, busy_prev = 1'b0, se0_prev = 1'b0;
  bit   dec_prev = 1'b1;
  int   dec_ones = 0, dec_sync = 0, dec_nb = 0;
  logic [7:0] dec_sh = 8'd0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic push_ev(input ev_e k, input int off);
    ev_t e;
    e.kind = k;
    e.off  = off;
    exp_ev_q.push_back(e);
  endtask

  task automatic got_ev(input ev_e k, input int off);
    ev_t e;
    checks++;
    if (exp_ev_q.size() == 0) begin
      $display("FAIL event_unexpected: got %s at +%0d, none required", k.name(), off);
    end else begin
      e = exp_ev_q.pop_front();
      if (e.kind == k && e.off == off) passed++;
      else $display("FAIL event_%s: got %s at +%0d, required %s at +%0d",
                    e.kind.name(), k.name(), off, e.kind.name(), e.off);
    end
  endtask

  // Receive-side model: NRZI decode, drop SYNC, remove stuffed bits, rebuild bytes
  task automatic decode_bit(input bit lvl);
    bit b;
    logic [7:0] eb;
    if (exp_line_q.size() != 0) chk("line_level", 8'(lvl), 8'(exp_line_q.pop_front()));
    b = (lvl == dec_prev);
    dec_prev = lvl;
    if (dec_ones == 6) begin
      chk("stuff_bit", 8'(b), 8'd0);
      dec_ones = 0;
    end else begin
      dec_ones = b ? dec_ones + 1 : 0;
      if (dec_sync < 8) begin
        dec_sync++;
      end else begin
        dec_sh = {b, dec_sh[7:1]};
        dec_nb++;
        if (dec_nb == 8) begin
          dec_nb = 0;
          checks++;
          if (exp_byte_q.size() == 0) begin
            $display("FAIL rx_byte: got %02h, none required", dec_sh);
          end else begin
            eb = exp_byte_q.pop_front();
            if (eb == dec_sh) passed++;
            else $display("FAIL rx_byte: got %02h, required %02h", dec_sh, eb);
          end
        end
      end
    end
  endtask

  // Monitor: turn output activity into timestamped events relative to packet start
  always @(negedge useClk) begin
    bit se0;
    cyc++;
    if (mon_en) begin
      se0 = !serialDataOut && !NotserialDataOut;
      if (txif.txReady === 1'b1) got_ev(EV_READY, cyc - t0);
      if (underrun === 1'b1) got_ev(EV_UNDERRUN, cyc - t0);
      if (se0 && !se0_prev) got_ev(EV_SE0, cyc - t0);
      if (!OE_TRANSMIT && oe_prev) begin
        got_ev(EV_OE_FALL, cyc - t0);
        chk("line_j_after_oe", {6'd0, serialDataOut, NotserialDataOut}, 8'b10);
        oe_fall_cyc = cyc;
      end
      if (!busy && busy_prev) got_ev(EV_BUSY_FALL, cyc - t0);
      if (OE_TRANSMIT && !oe_prev) begin
        if (busy_prev) got_ev(EV_OE_RISE, cyc - oe_fall_cyc);
        t0 = cyc;
        dec_prev = 1'b1;
        dec_ones = 0;
        dec_sync = 0;
        dec_nb   = 0;
        dec_sh   = 8'd0;
      end
      if (OE_TRANSMIT && !se0 && ((cyc - t0) % N == N / 2)) decode_bit(serialDataOut);
      oe_prev   = OE_TRANSMIT;
      busy_prev = busy;
      se0_prev  = se0;
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge useClk);
      if (txif.txReady === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (ok) passed++;
    else $display("FAIL ready_timeout: got no txReady in 400 cycles, required one");
  endtask

  task automatic wait_busy_low();
    bit ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge useClk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (ok) passed++;
    else $display("FAIL busy_timeout: busy still %b after 600 cycles, required 0", busy);
    repeat (3) @(negedge useClk);
  endtask

  // Send n (1 or 2) bytes; mark_last controls txLast on the final byte
  task automatic send(input logic [7:0] d0, input logic [7:0] d1, input int n, input bit mark_last);
    bit ok;
    txif.txValid = 1'b1;
    txif.txData  = d0;
    txif.txLast  = (n == 1) && mark_last;
    for (int i = 0; i < n; i++) begin
      wait_ready(ok);
      if (!ok) break;
      if (i + 1 < n) begin
        txif.txData = d1;
        txif.txLast = mark_last;
      end else begin
        txif.txValid = 1'b0;
        txif.txLast  = 1'b0;
      end
    end
    txif.txValid = 1'b0;
  endtask

  task automatic push_c3_line();
    bit pat[16] = '{0,1,0,1,0,1,0,0, 0,0,1,0,1,0,0,0};
    foreach (pat[i]) exp_line_q.push_back(pat[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst          = 1'b1;
    txif.txValid = 1'b0;
    txif.txData  = 8'h00;
    txif.txLast  = 1'b0;
    repeat (3) @(negedge useClk);
    chk("reset_dp", 8'(serialDataOut), 8'd1);
    chk("reset_dm", 8'(NotserialDataOut), 8'd0);
    chk("reset_oe", 8'(OE_TRANSMIT), 8'd0);
    chk("reset_busy", 8'(busy), 8'd0);
    chk("reset_ready", 8'(txif.txReady), 8'd0);
    chk("reset_underrun", 8'(underrun), 8'd0);
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (5) @(negedge useClk);

    // Single byte 0xC3
    push_ev(EV_READY, 80); push_ev(EV_SE0, 160); push_ev(EV_OE_FALL, 190); push_ev(EV_BUSY_FALL, 210);
    exp_byte_q.push_back(8'hC3);
    push_c3_line();
    send(8'hC3, 8'h00, 1, 1'b1);
    wait_busy_low();

    // 0xFF, 0xFF: one stuff bit inside each byte
    push_ev(EV_READY, 80); push_ev(EV_READY, 170); push_ev(EV_SE0, 260);
    push_ev(EV_OE_FALL, 290); push_ev(EV_BUSY_FALL, 310);
    exp_byte_q.push_back(8'hFF); exp_byte_q.push_back(8'hFF);
    send(8'hFF, 8'hFF, 2, 1'b1);
    wait_busy_low();

    // 0xFC: stuff bit owed before EOP
    push_ev(EV_READY, 80); push_ev(EV_SE0, 170); push_ev(EV_OE_FALL, 200); push_ev(EV_BUSY_FALL, 220);
    exp_byte_q.push_back(8'hFC);
    send(8'hFC, 8'h00, 1, 1'b1);
    wait_busy_low();

    // Underrun: 0x01 without txLast, then no data
    push_ev(EV_READY, 80); push_ev(EV_UNDERRUN, 160); push_ev(EV_SE0, 160);
    push_ev(EV_OE_FALL, 190); push_ev(EV_BUSY_FALL, 210);
    exp_byte_q.push_back(8'h01);
    send(8'h01, 8'h00, 1, 1'b0);
    wait_busy_low();

    // Reset mid-packet, sampled at the edge T0+96
    push_ev(EV_READY, 80); push_ev(EV_OE_FALL, 96); push_ev(EV_BUSY_FALL, 96);
    txif.txValid = 1'b1;
    txif.txData  = 8'hA5;
    txif.txLast  = 1'b1;
    wait_ready(ok);
    txif.txValid = 1'b0;
    txif.txLast  = 1'b0;
    repeat (15) @(negedge useClk);
    rst = 1'b1;
    @(negedge useClk);
    rst = 1'b0;
    chk("rst_mid_oe", 8'(OE_TRANSMIT), 8'd0);
    chk("rst_mid_busy", 8'(busy), 8'd0);
    chk("rst_mid_line", {6'd0, serialDataOut, NotserialDataOut}, 8'b10);
    repeat (5) @(negedge useClk);

    // Fresh packet after reset
    push_ev(EV_READY, 80); push_ev(EV_SE0, 160); push_ev(EV_OE_FALL, 190); push_ev(EV_BUSY_FALL, 210);
    exp_byte_q.push_back(8'hC3);
    push_c3_line();
    send(8'hC3, 8'h00, 1, 1'b1);
    wait_busy_low();

    // txValid held across two packets: restart 2N after OE drops, busy never falls between
    push_ev(EV_READY, 80); push_ev(EV_SE0, 160); push_ev(EV_OE_FALL, 190); push_ev(EV_OE_RISE, 20);
    push_ev(EV_READY, 80); push_ev(EV_SE0, 160); push_ev(EV_OE_FALL, 190); push_ev(EV_BUSY_FALL, 210);
    exp_byte_q.push_back(8'h5A); exp_byte_q.push_back(8'h3C);
    txif.txValid = 1'b1;
    txif.txData  = 8'h5A;
    txif.txLast  = 1'b1;
    wait_ready(ok);
    txif.txData  = 8'h3C;
    wait_ready(ok);
    txif.txValid = 1'b0;
    txif.txLast  = 1'b0;
    wait_busy_low();

    repeat (20) @(negedge useClk);
    chk("events_left", 8'(exp_ev_q.size()), 8'd0);
    chk("bytes_left", 8'(exp_byte_q.size()), 8'd0);
    chk("line_left", 8'(exp_line_q.size()), 8'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
